ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  PS/2 keyboard receiver and scancode-set-2 make/break decoder.
//  Drives the held-key levels key_space/key_left/key_right that feed the player rectangle controller.
//  Sits between the board PS/2 pins and the movement FSM.
//  One level per key: high from make code to break code.
// PARAMETERS
//  FILTER_LEN      4        consecutive equal ps2_clk samples needed to accept a new ps2_clk level
//  TIMEOUT_CYCLES  200_000  max clk cycles between falling ps2_clk edges inside a frame
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data    in   1  raw PS/2 data pin (asynchronous)
//  key_space   out  1  level: jump key held
//  key_left    out  1  level: left key held
//  key_right   out  1  level: right key held
//  scan_valid  out  1  1-cycle pulse: good byte received
//  scan_code   out  8  last good byte; holds until the next good byte
//  frame_err   out  1  1-cycle pulse: parity, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; ext/brk flags 0; filter and synchronisers preset to 1 (bus idle).
//  Reset is honoured at any time, including mid-frame; the partial frame is discarded.
//  Input path:
//   - 2-flop synchroniser on each pin.
//   - ps2_clk filter: accepted level changes only after FILTER_LEN identical samples.
//   - fall = accepted level goes 1->0; data is sampled from synchronised ps2_data on fall.
//  Frame FSM (11-bit frame: start=0, 8 data LSB-first, odd parity, stop=1):
//   - IDLE: fall with data=0 -> DATA, bit count 0. Fall with data=1 -> stay IDLE, no error.
//   - DATA: shift on each fall; after the 8th bit -> PARITY.
//   - PARITY: store the bit -> STOP.
//   - STOP: on fall, good byte if data=1 and ^{byte,parity}==1; otherwise frame_err. Then -> IDLE.
//   - Timeout: watchdog reloads on every fall; counts only outside IDLE.
//     Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, byte discarded.
//  Latency: fall of stop bit detected in cycle N.
//   - scan_valid/scan_code at N+1.
//   - key outputs updated at N+2.
//  Decoder (acts on each good byte):
//   - 0xE0 -> ext=1.
//   - 0xF0 -> brk=1.
//   - Any other byte: look up (ext, byte); key <= !brk on a hit; then ext=brk=0.
//   - Map: {0,0x29} space; {1,0x6B} left; {1,0x74} right.
//   - Non-extended 0x6B/0x74 (keypad) and all other codes are unmapped: flags clear, keys unchanged.
//   - 0xAA/0xFA/0xFE are unmapped; no special handling.
//   - frame_err also clears ext and brk; key levels are kept.
//  Keys are independent: any combination may be high at once.
//   - Repeated make codes (typematic) leave the level high.
//   - A break code for a key that is not held leaves it low.
// CONFIGURATION
//  KEY_DECODER_WASD_EN defined:
//   - Additional non-extended map: 0x1D (W) -> key_space, 0x1C (A) -> key_left, 0x23 (D) -> key_right.
//   - Each output is the OR of two internal held flags: arrow/space and WASD.
//   - Releasing one source does not drop the output while the other source is still held.
//  Not defined: only the base map; 0x1D/0x1C/0x23 are unmapped. Identical port list in both builds.
// TESTING
//  1. Frame 0x29 good parity -> scan_valid pulse with scan_code=0x29; key_space=1 two cycles after the stop fall.
//     Then F0,29 -> key_space=0.
//  2. E0,6B then E0,74 -> key_left=1 and key_right=1 together.
//     Then E0,F0,6B -> key_left=0 while key_right stays 1.
//  3. Byte 0x6B without E0 -> scan_valid=1, all keys unchanged.
//     Then 0x29 -> key_space=1, confirming the ext flag was not left set.
//  4. Frame 0x29 with even parity -> frame_err pulse, no scan_valid, key_space stays 0.
//     Then frame with stop=0 -> frame_err.
//  5. Stop ps2_clk after 5 bits -> frame_err exactly TIMEOUT_CYCLES after the last fall.
//     Next full 0x29 frame decodes correctly.
//  6. Assert rst_n=0 mid-frame with key_left held -> all outputs 0 immediately.
//     After release, a clean E0,74 sets key_right=1.
//     With KEY_DECODER_WASD_EN: 1C and E0,6B held, then F0,1C -> key_left stays 1.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 receiver with scancode-set-2 make/break decoding into held-key levels.
// Optional WASD aliases are enabled by defining KEY_DECODER_WASD_EN.
//   state  | meaning
//   IDLE   | bus idle, waiting for a start bit
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking the stop bit and parity
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] FILT_TC   = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           clk_f_q;
  logic [FCW-1:0] fcnt_q;
  logic           fall;
  state_t         state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic [TW-1:0]  wd_q;
  logic           scan_valid_q, frame_err_q;
  logic [7:0]     scan_code_q;
  logic           ext_q, brk_q;
  logic           space_q, left_q, right_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Accepted level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f_q <= 1'b1;
      fcnt_q  <= '0;
    end else if (clk_s2_q == clk_f_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FILT_TC) begin
      clk_f_q <= clk_s2_q;
      fcnt_q  <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end

  assign fall = clk_f_q & ~clk_s2_q & (fcnt_q == FILT_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wd_q         <= TO_RELOAD;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        wd_q <= TO_RELOAD;
      end else if (state_q != S_IDLE && wd_q != '0) begin
        wd_q <= wd_q - TW'(1);
      end
      if (!fall && state_q != S_IDLE && wd_q == '0) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
      end else if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          default: begin
            if (dat_s2_q && (^{shift_q, par_q})) begin
              scan_valid_q <= 1'b1;
              scan_code_q  <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef KEY_DECODER_WASD_EN
  logic w_q, a_q, d_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      space_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
`ifdef KEY_DECODER_WASD_EN
      w_q     <= 1'b0;
      a_q     <= 1'b0;
      d_q     <= 1'b0;
`endif
    end else if (frame_err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (scan_valid_q) begin
      if (scan_code_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (scan_code_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (!ext_q && scan_code_q == 8'h29) space_q <= !brk_q;
        if (ext_q && scan_code_q == 8'h6B)  left_q  <= !brk_q;
        if (ext_q && scan_code_q == 8'h74)  right_q <= !brk_q;
`ifdef KEY_DECODER_WASD_EN
        if (!ext_q && scan_code_q == 8'h1D) w_q <= !brk_q;
        if (!ext_q && scan_code_q == 8'h1C) a_q <= !brk_q;
        if (!ext_q && scan_code_q == 8'h23) d_q <= !brk_q;
`endif
      end
    end
  end

`ifdef KEY_DECODER_WASD_EN
  assign key_space = space_q | w_q;
  assign key_left  = left_q | a_q;
  assign key_right = right_q | d_q;
`else
  assign key_space = space_q;
  assign key_left  = left_q;
  assign key_right = right_q;
`endif
  assign scan_valid = scan_valid_q;
  assign scan_code  = scan_code_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder against a key-table reference model.
// Honours KEY_DECODER_WASD_EN the same way the design does.
module tb_ps2_key_decoder;
  localparam int FILT    = 4;
  localparam int TO      = 300;
  localparam int HALF    = 12;
  localparam int PIN_LAT = 2 + FILT;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data;
  logic       key_space, key_left, key_right, scan_valid, frame_err;
  logic [7:0] scan_code;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_space(key_space), .key_left(key_left), .key_right(key_right),
    .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
  );

  int n_cmp = 0, n_err = 0;
  int sv_cnt = 0, fe_cnt = 0;
  bit held[6];
  bit m_ext, m_brk;
  logic [7:0] m_code;
  logic [7:0] codes[6] = '{8'h29, 8'h6B, 8'h74, 8'h1D, 8'h1C, 8'h23};

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (scan_valid) sv_cnt++;
      if (frame_err) fe_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int key_idx(input bit ext, input logic [7:0] b);
    if (!ext && b == 8'h29) return 0;
    if (ext && b == 8'h6B) return 1;
    if (ext && b == 8'h74) return 2;
`ifdef KEY_DECODER_WASD_EN
    if (!ext && b == 8'h1D) return 3;
    if (!ext && b == 8'h1C) return 4;
    if (!ext && b == 8'h23) return 5;
`endif
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit good);
    int k;
    if (!good) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_code = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        k = key_idx(m_ext, b);
        if (k >= 0) held[k] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  task automatic model_reset();
    foreach (held[i]) held[i] = 0;
    m_ext = 0;
    m_brk = 0;
    m_code = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_keys(input string tag);
    check_eq({tag, ":key_space"}, key_space, held[0] | held[3]);
    check_eq({tag, ":key_left"},  key_left,  held[1] | held[4]);
    check_eq({tag, ":key_right"}, key_right, held[2] | held[5]);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Optional short low glitch during the high phase must be filtered out.
  task automatic drive_bit(input bit b, input bit glitch);
    int g;
    ps2_data = b;
    if (glitch) begin
      g = $urandom_range(1, FILT - 1);
      tick(3);
      ps2_clk = 0;
      tick(g);
      ps2_clk = 1;
      tick(HALF - 3 - g);
    end else begin
      tick(HALF);
    end
    ps2_clk = 0;
    tick(HALF);
    ps2_clk = 1;
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input bit bad_par,
                      input bit bad_stop, input bit glitch);
    int sv0, fe0;
    logic [10:0] f;
    bit good;
    sv0 = sv_cnt;
    fe0 = fe_cnt;
    f = mk_frame(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) drive_bit(f[i], glitch && ($urandom_range(0, 3) == 0));
    tick(HALF);
    good = !bad_par && !bad_stop;
    model_byte(b, good);
    check_eq({tag, ":valid_pulses"}, sv_cnt - sv0, good);
    check_eq({tag, ":err_pulses"}, fe_cnt - fe0, !good);
    check_eq({tag, ":scan_code"}, scan_code, m_code);
    check_keys(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] f;
    int fe0, sv0, k, mk, n;
    rst_n = 0;
    ps2_clk = 1;
    ps2_data = 1;
    model_reset();
    tick(3);
    check_eq("rst:scan_valid", scan_valid, 0);
    check_eq("rst:frame_err", frame_err, 0);
    check_eq("rst:scan_code", scan_code, 0);
    check_keys("rst");
    rst_n = 1;
    tick(5);

    // make 0x29 with exact latency on the stop-bit fall
    f = mk_frame(8'h29, 0, 0);
    for (int i = 0; i < 10; i++) drive_bit(f[i], 0);
    ps2_data = 1;
    tick(HALF);
    ps2_clk = 0;
    for (int j = 1; j <= PIN_LAT + 1; j++) begin
      tick(1);
      check_eq("lat:scan_valid", scan_valid, j == PIN_LAT);
      check_eq("lat:key_space", key_space, j > PIN_LAT);
      if (j == PIN_LAT) check_eq("lat:scan_code", scan_code, 8'h29);
    end
    tick(HALF - PIN_LAT - 1);
    ps2_clk = 1;
    tick(HALF);
    model_byte(8'h29, 1);
    xfer("brk29_f0", 8'hF0, 0, 0, 0);
    xfer("brk29", 8'h29, 0, 0, 0);

    xfer("l_e0", 8'hE0, 0, 0, 0);
    xfer("l_6b", 8'h6B, 0, 0, 0);
    xfer("r_e0", 8'hE0, 0, 0, 0);
    xfer("r_74", 8'h74, 0, 0, 0);
    xfer("lb_e0", 8'hE0, 0, 0, 0);
    xfer("lb_f0", 8'hF0, 0, 0, 0);
    xfer("lb_6b", 8'h6B, 0, 0, 0);

    xfer("kp_6b", 8'h6B, 0, 0, 0);
    xfer("after_kp_29", 8'h29, 0, 0, 0);
    xfer("b_f0", 8'hF0, 0, 0, 0);
    xfer("b_29", 8'h29, 0, 0, 0);

    xfer("bad_par", 8'h29, 1, 0, 0);
    xfer("bad_stop", 8'h29, 0, 1, 0);

    // stall after 5 bits; frame_err exactly TO cycles after the last fall
    fe0 = fe_cnt;
    f = mk_frame(8'h29, 0, 0);
    for (int i = 0; i < 4; i++) drive_bit(f[i], 0);
    ps2_data = f[4];
    tick(HALF);
    ps2_clk = 0;
    for (int j = 1; j <= PIN_LAT + TO; j++) begin
      tick(1);
      if (j == HALF) ps2_clk = 1;
      if (j >= PIN_LAT + TO - 1) check_eq("timeout:frame_err", frame_err, j == PIN_LAT + TO);
    end
    tick(5);
    check_eq("timeout:err_pulses", fe_cnt - fe0, 1);
    model_byte(8'h00, 0);
    xfer("post_to_29", 8'h29, 0, 0, 0);

    // reset mid-frame with key_left held
    xfer("rl_e0", 8'hE0, 0, 0, 0);
    xfer("rl_6b", 8'h6B, 0, 0, 0);
    f = mk_frame(8'h74, 0, 0);
    for (int i = 0; i < 4; i++) drive_bit(f[i], 0);
    rst_n = 0;
    #1;
    model_reset();
    check_eq("midrst:scan_code", scan_code, 0);
    check_eq("midrst:scan_valid", scan_valid, 0);
    check_eq("midrst:frame_err", frame_err, 0);
    check_keys("midrst");
    ps2_clk = 1;
    ps2_data = 1;
    tick(3);
    rst_n = 1;
    tick(5);
    xfer("pr_e0", 8'hE0, 0, 0, 0);
    xfer("pr_74", 8'h74, 0, 0, 0);

    // WASD overlap with arrows (unmapped aliases in the base build)
    xfer("ov_1c", 8'h1C, 0, 0, 0);
    xfer("ov_e0", 8'hE0, 0, 0, 0);
    xfer("ov_6b", 8'h6B, 0, 0, 0);
    xfer("ov_f0", 8'hF0, 0, 0, 0);
    xfer("ov_1c_brk", 8'h1C, 0, 0, 0);

    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(0, 99);
      if (n < 8) begin
        xfer("rnd_noise", 8'($urandom), 0, 0, $urandom_range(0, 4) == 0);
      end else if (n < 14) begin
        xfer("rnd_par", 8'($urandom), 1, 0, 0);
      end else if (n < 17) begin
        xfer("rnd_stop", 8'($urandom), 0, 1, 0);
      end else begin
        k = $urandom_range(0, 5);
        mk = $urandom_range(0, 1);
        if (k == 1 || k == 2) xfer("rnd_e0", 8'hE0, 0, 0, $urandom_range(0, 4) == 0);
        if (mk == 0) xfer("rnd_f0", 8'hF0, 0, 0, $urandom_range(0, 4) == 0);
        xfer("rnd_code", codes[k], 0, 0, $urandom_range(0, 4) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
